// File: rtl/riscv_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests, and buffers {inst, pc} for decode.
// Redirects clear the buffer and count the stale in-flight responses that must be dropped.
module riscv_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_pc_in,
  output logic        imem_req_valid_out,
  input  logic        imem_req_ready_in,
  output logic [31:0] imem_addr_out,
  input  logic        imem_rsp_valid_in,
  input  logic [31:0] imem_rsp_data_in,
  output logic        inst_valid_out,
  input  logic        inst_ready_in,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);
  localparam int unsigned PTR_W = $clog2(FB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FB_DEPTH);

  typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] pc_cnt_q, pc_cnt_d, data_cnt_q, data_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [PTR_W-1:0] pc_wptr_q, pc_wptr_d, pc_rptr_q, pc_rptr_d;
  logic [PTR_W-1:0] data_wptr_q, data_wptr_d, data_rptr_q, data_rptr_d;
  logic [31:0]      pc_mem_q   [FB_DEPTH];
  logic [31:0]      data_mem_q [FB_DEPTH];

  logic             req_fire, out_fire, rsp_push;
  logic [CNT_W-1:0] in_flight, redirect_drop;

  // Requests are gated by redirect so a fire never coincides with a PC reload.
  assign imem_req_valid_out = (state_q == S_RUN) && (pc_cnt_q < DEPTH_C) && !redirect_valid_in;
  assign imem_addr_out      = pc_q;
  assign inst_valid_out     = (data_cnt_q != '0);
  assign inst_out           = inst_valid_out ? data_mem_q[data_rptr_q] : '0;
  assign pc_out             = inst_valid_out ? pc_mem_q[pc_rptr_q] : '0;

  assign req_fire  = imem_req_valid_out && imem_req_ready_in;
  assign out_fire  = inst_valid_out && inst_ready_in;
  assign rsp_push  = imem_rsp_valid_in && (state_q == S_RUN) && !redirect_valid_in;
  assign in_flight = pc_cnt_q - data_cnt_q;
  assign redirect_drop = in_flight + ((state_q == S_FLUSH) ? drop_cnt_q : '0)
                         - CNT_W'(imem_rsp_valid_in);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_cnt_d  = drop_cnt_q;
    pc_cnt_d    = pc_cnt_q + CNT_W'(req_fire) - CNT_W'(out_fire);
    data_cnt_d  = data_cnt_q + CNT_W'(rsp_push) - CNT_W'(out_fire);
    pc_wptr_d   = pc_wptr_q + PTR_W'(req_fire);
    pc_rptr_d   = pc_rptr_q + PTR_W'(out_fire);
    data_wptr_d = data_wptr_q + PTR_W'(rsp_push);
    data_rptr_d = data_rptr_q + PTR_W'(out_fire);

    unique case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (req_fire) pc_d = pc_q + 32'd4;
      S_FLUSH: begin
        if (imem_rsp_valid_in && (drop_cnt_q != '0)) begin
          drop_cnt_d = drop_cnt_q - CNT_W'(1);
          if (drop_cnt_q == CNT_W'(1)) state_d = S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase

    // Redirect wins over everything: the buffer is discarded, and the head consumed this cycle is gone anyway.
    if (redirect_valid_in) begin
      pc_d        = redirect_pc_in & ~32'h3;
      pc_cnt_d    = '0;
      data_cnt_d  = '0;
      pc_wptr_d   = '0;
      pc_rptr_d   = '0;
      data_wptr_d = '0;
      data_rptr_d = '0;
      drop_cnt_d  = redirect_drop;
      state_d     = (redirect_drop != '0) ? S_FLUSH : S_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      pc_cnt_q    <= '0;
      data_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      pc_wptr_q   <= '0;
      pc_rptr_q   <= '0;
      data_wptr_q <= '0;
      data_rptr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_cnt_q    <= pc_cnt_d;
      data_cnt_q  <= data_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      pc_wptr_q   <= pc_wptr_d;
      pc_rptr_q   <= pc_rptr_d;
      data_wptr_q <= data_wptr_d;
      data_rptr_q <= data_rptr_d;
    end
  end

  // Storage is left unreset; outputs are masked by valid instead.
  for (genvar gi = 0; gi < FB_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (req_fire && (pc_wptr_q == PTR_W'(gi))) pc_mem_q[gi] <= pc_q;
      if (rsp_push && (data_wptr_q == PTR_W'(gi))) data_mem_q[gi] <= imem_rsp_data_in;
    end
  end

  rsp_credit_a: assert property (@(posedge clk) disable iff (!reset)
    !(rsp_push && (data_cnt_q == DEPTH_C)));

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Directed bench for riscv_fetch_stage: queue-based imem responder, stall/refill, async reset and a redirect table.
module tb_riscv_fetch_stage;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;
  logic        imem_req_valid_out;
  logic        imem_req_ready_in;
  logic [31:0] imem_addr_out;
  logic        imem_rsp_valid_in;
  logic [31:0] imem_rsp_data_in;
  logic        inst_valid_out;
  logic        inst_ready_in;
  logic [31:0] inst_out;
  logic [31:0] pc_out;

  logic        rsp_hold;
  logic [31:0] pend[$];
  logic [31:0] req_log[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int          n_inflight;
    bit          same_rsp;
    logic [31:0] target;
    logic [31:0] exp_pc;
    logic        exp_req_next;
  } redir_vec_t;
  redir_vec_t vecs[4];

  riscv_fetch_stage #(.RESET_PC(RST_PC), .FB_DEPTH(2)) dut (
    .clk                (clk),
    .reset              (reset),
    .redirect_valid_in  (redirect_valid_in),
    .redirect_pc_in     (redirect_pc_in),
    .imem_req_valid_out (imem_req_valid_out),
    .imem_req_ready_in  (imem_req_ready_in),
    .imem_addr_out      (imem_addr_out),
    .imem_rsp_valid_in  (imem_rsp_valid_in),
    .imem_rsp_data_in   (imem_rsp_data_in),
    .inst_valid_out     (inst_valid_out),
    .inst_ready_in      (inst_ready_in),
    .inst_out           (inst_out),
    .pc_out             (pc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int k);
    if (k < q.size()) return q[k];
    return 32'hDEAD_BEEF;
  endfunction

  // imem: accepted at negedge, returned one cycle later unless held back
  always @(negedge clk)
    if (reset && imem_req_valid_out && imem_req_ready_in) pend.push_back(word_of(imem_addr_out));

  always @(posedge clk) begin
    #2;
    if (!reset) begin
      pend.delete();
      imem_rsp_valid_in = 1'b0;
      imem_rsp_data_in  = '0;
    end else if (!rsp_hold && pend.size() != 0) begin
      imem_rsp_valid_in = 1'b1;
      imem_rsp_data_in  = pend.pop_front();
    end else begin
      imem_rsp_valid_in = 1'b0;
      imem_rsp_data_in  = '0;
    end
  end

  always @(negedge clk) begin
    if (reset && imem_req_valid_out && imem_req_ready_in) req_log.push_back(imem_addr_out);
    if (reset && inst_valid_out && inst_ready_in) begin
      got_pc.push_back(pc_out);
      got_inst.push_back(inst_out);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    got_pc.delete();
    got_inst.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_got(input int n, input int budget, input string name);
    int c = 0;
    while (got_pc.size() < n && c < budget) begin
      cycles(1);
      c++;
    end
    checks++;
    if (got_pc.size() < n) begin
      errors++;
      $display("FAIL %s: got %0d instructions expected %0d", name, got_pc.size(), n);
    end
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1 reset = 1'b0;
    clear_logs();
    cycles(2);
    reset = 1'b1;
  endtask

  initial begin
    vecs[0] = '{n_inflight: 2, same_rsp: 1'b0, target: 32'h0000_0100, exp_pc: 32'h0000_0100, exp_req_next: 1'b0};
    vecs[1] = '{n_inflight: 2, same_rsp: 1'b1, target: 32'h0000_0103, exp_pc: 32'h0000_0100, exp_req_next: 1'b0};
    vecs[2] = '{n_inflight: 1, same_rsp: 1'b1, target: 32'h0000_2002, exp_pc: 32'h0000_2000, exp_req_next: 1'b1};
    vecs[3] = '{n_inflight: 1, same_rsp: 1'b0, target: 32'hFFFF_FFFF, exp_pc: 32'hFFFF_FFFC, exp_req_next: 1'b0};

    reset = 1'b0;
    redirect_valid_in = 1'b0;
    redirect_pc_in = '0;
    imem_req_ready_in = 1'b1;
    inst_ready_in = 1'b0;
    rsp_hold = 1'b0;
    imem_rsp_valid_in = 1'b0;
    imem_rsp_data_in = '0;

    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid_out), 32'd0);
    check("rst_addr", imem_addr_out, RST_PC);
    check("rst_inst_valid", 32'(inst_valid_out), 32'd0);
    check("rst_inst", inst_out, 32'd0);
    check("rst_pc", pc_out, 32'd0);

    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("boot_no_req", 32'(imem_req_valid_out), 32'd0);
    cycles(1);
    @(negedge clk);
    check("first_req_valid", 32'(imem_req_valid_out), 32'd1);
    check("first_req_addr", imem_addr_out, RST_PC);

    // decode stalled: the buffer fills with two words and requests stop
    cycles(5);
    @(negedge clk);
    $display("stall: %0d requests issued", req_log.size());
    check("stall_req_count", 32'(req_log.size()), 32'd2);
    check("stall_req0", qget(req_log, 0), 32'hFFFF_FFF8);
    check("stall_req1", qget(req_log, 1), 32'hFFFF_FFFC);
    check("stall_req_valid", 32'(imem_req_valid_out), 32'd0);
    check("stall_inst_valid", 32'(inst_valid_out), 32'd1);
    check("stall_inst", inst_out, word_of(32'hFFFF_FFF8));
    check("stall_pc", pc_out, 32'hFFFF_FFF8);
    cycles(1);
    @(negedge clk);
    check("stall_hold_inst", inst_out, word_of(32'hFFFF_FFF8));

    cycles(1);
    inst_ready_in = 1'b1;
    wait_got(3, 20, "release_stream");
    for (int k = 0; k < 3; k++) begin
      logic [31:0] e;
      e = 32'hFFFF_FFF8 + 32'(4 * k);
      $display("release: pc %h inst %h", qget(got_pc, k), qget(got_inst, k));
      check("release_pc", qget(got_pc, k), e);
      check("release_inst", qget(got_inst, k), word_of(e));
    end

    // refill the buffer, then hit it with an asynchronous reset mid-cycle
    inst_ready_in = 1'b0;
    cycles(6);
    @(negedge clk);
    check("refill_valid", 32'(inst_valid_out), 32'd1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_req_valid", 32'(imem_req_valid_out), 32'd0);
    check("async_addr", imem_addr_out, RST_PC);
    check("async_inst_valid", 32'(inst_valid_out), 32'd0);
    check("async_inst", inst_out, 32'd0);
    check("async_pc", pc_out, 32'd0);
    cycles(1);
    clear_logs();
    inst_ready_in = 1'b1;
    cycles(1);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_no_stale", 32'(inst_valid_out), 32'd0);
    check("post_rst_boot_req", 32'(imem_req_valid_out), 32'd0);

    wait_got(5, 40, "stream");
    for (int k = 0; k < 5; k++) begin
      logic [31:0] e;
      e = RST_PC + 32'(4 * k);
      $display("stream: req %h pc %h inst %h", qget(req_log, k), qget(got_pc, k), qget(got_inst, k));
      check("stream_req", qget(req_log, k), e);
      check("stream_pc", qget(got_pc, k), e);
      check("stream_inst", qget(got_inst, k), word_of(e));
    end

    // redirect table
    for (int v = 0; v < 4; v++) begin
      int c;
      logic [31:0] e1;
      rsp_hold = 1'b1;
      inst_ready_in = 1'b1;
      reset_dut();
      c = 0;
      while (req_log.size() < vecs[v].n_inflight && c < 10) begin
        cycles(1);
        c++;
      end
      check("redir_setup_reqs", 32'(req_log.size()), 32'(vecs[v].n_inflight));
      redirect_valid_in = 1'b1;
      redirect_pc_in = vecs[v].target;
      rsp_hold = !vecs[v].same_rsp;
      clear_logs();
      @(negedge clk);
      check("redir_cycle_no_req", 32'(imem_req_valid_out), 32'd0);
      cycles(1);
      redirect_valid_in = 1'b0;
      rsp_hold = 1'b0;
      @(negedge clk);
      check("redir_next_req_valid", 32'(imem_req_valid_out), 32'(vecs[v].exp_req_next));
      wait_got(2, 30, "redir_stream");
      e1 = vecs[v].exp_pc + 32'd4;
      $display("redirect %0d: target %h first pc %h inst %h", v, vecs[v].target,
               qget(got_pc, 0), qget(got_inst, 0));
      check("redir_req0", qget(req_log, 0), vecs[v].exp_pc);
      check("redir_req1", qget(req_log, 1), e1);
      check("redir_pc0", qget(got_pc, 0), vecs[v].exp_pc);
      check("redir_inst0", qget(got_inst, 0), word_of(vecs[v].exp_pc));
      check("redir_pc1", qget(got_pc, 1), e1);
      check("redir_inst1", qget(got_inst, 1), word_of(e1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "time limit");
  end

endmodule
